// File: rtl/mode_input_ctrl_if.sv
// Button inputs and mode/pause/clear outputs of the mode input controller.
// The master drives the raw buttons; the slave (the controller) drives the mode outputs.
interface mode_input_ctrl_if;
  logic btn_mode;
  logic btn_pause;
  logic btn_clear;
  logic mode_clock;
  logic mode_stopwatch;
  logic mode_countdown;
  logic pause;
  logic clear;
  logic mode_changed;

  modport master (
    output btn_mode,
    output btn_pause,
    output btn_clear,
    input  mode_clock,
    input  mode_stopwatch,
    input  mode_countdown,
    input  pause,
    input  clear,
    input  mode_changed
  );

  modport slave (
    input  btn_mode,
    input  btn_pause,
    input  btn_clear,
    output mode_clock,
    output mode_stopwatch,
    output mode_countdown,
    output pause,
    output clear,
    output mode_changed
  );
endinterface

// File: rtl/mode_input_ctrl.sv
// Pushbutton front end: synchronise, debounce and edge-detect three buttons, then drive
// the registered one-hot mode selects, the pause level and the one-cycle clear pulse.
module mode_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input logic            clk,
  input logic            reset,
  mode_input_ctrl_if.slave bus
);

  localparam int BtnMode  = 0;
  localparam int BtnPause = 1;
  localparam int BtnClear = 2;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    StClock     = 3'b001,
    StStopwatch = 3'b010,
    StCountdown = 3'b100
  } mode_e;

  logic [2:0]            raw;
  logic [2:0]            sync1_q, sync2_q;
  logic [2:0]            stable_q, stable_d;
  logic [2:0]            stable_prev_q;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]            press;

  mode_e state_q, state_d;
  logic  pause_q, pause_d;
  logic  clear_q, clear_d;
  logic  changed_q, changed_d;

  assign raw = {bus.btn_clear, bus.btn_pause, bus.btn_mode};

  // A stable state only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign press = stable_q & ~stable_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  // A mode press outranks a pause press and always leaves the new mode unpaused.
  always_comb begin
    state_d   = state_q;
    pause_d   = pause_q;
    clear_d   = press[BtnClear];
    changed_d = 1'b0;
    if (press[BtnMode]) begin
      changed_d = 1'b1;
      pause_d   = 1'b0;
      unique case (state_q)
        StClock:     state_d = StStopwatch;
        StStopwatch: state_d = StCountdown;
        StCountdown: state_d = StClock;
        default:     state_d = StClock;
      endcase
    end else if (press[BtnPause]) begin
      pause_d = ~pause_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StClock;
      pause_q   <= 1'b0;
      clear_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pause_q   <= pause_d;
      clear_q   <= clear_d;
      changed_q <= changed_d;
    end
  end

  assign bus.mode_clock     = (state_q == StClock);
  assign bus.mode_stopwatch = (state_q == StStopwatch);
  assign bus.mode_countdown = (state_q == StCountdown);
  assign bus.pause          = pause_q;
  assign bus.clear          = clear_q;
  assign bus.mode_changed   = changed_q;

endmodule

// File: tb/tb_mode_input_ctrl.sv
// Self-checking bench for mode_input_ctrl with DEBOUNCE_CYCLES=4: per-cycle vector table
// plus a hand-written reset-during-debounce sequence.
module tb_mode_input_ctrl;

  localparam int unsigned Deb = 4;

  localparam logic [2:0] MClk = 3'b100;
  localparam logic [2:0] MSw  = 3'b010;
  localparam logic [2:0] MCd  = 3'b001;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mode_input_ctrl_if bus ();

  mode_input_ctrl #(
    .DEBOUNCE_CYCLES(Deb),
    .CNT_W          (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // exp = {mode_clock, mode_stopwatch, mode_countdown, pause, clear, mode_changed}
  typedef struct {
    logic       rst;
    logic       m;
    logic       p;
    logic       c;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [5:0] outs();
    return {bus.mode_clock, bus.mode_stopwatch, bus.mode_countdown,
            bus.pause, bus.clear, bus.mode_changed};
  endfunction

  task automatic add(input int n, input logic rst, input logic m, input logic p, input logic c,
                     input logic [2:0] md, input logic pz, input logic cl, input logic ch);
    vec_t v;
    v.rst = rst;
    v.m   = m;
    v.p   = p;
    v.c   = c;
    v.exp = {md, pz, cl, ch};
    repeat (n) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int edges;
    reset         = 1'b1;
    bus.btn_mode  = 1'b0;
    bus.btn_pause = 1'b0;
    bus.btn_clear = 1'b0;

    // Reset and idle
    add(1,  1, 0, 0, 0, MClk, 0, 0, 0);
    add(20, 0, 0, 0, 0, MClk, 0, 0, 0);
    // Mode presses: 12-cycle hold, then two 10-cycle holds, wrapping to clock
    add(6,  0, 1, 0, 0, MClk, 0, 0, 0);
    add(1,  0, 1, 0, 0, MSw,  0, 0, 1);
    add(5,  0, 1, 0, 0, MSw,  0, 0, 0);
    add(8,  0, 0, 0, 0, MSw,  0, 0, 0);
    add(6,  0, 1, 0, 0, MSw,  0, 0, 0);
    add(1,  0, 1, 0, 0, MCd,  0, 0, 1);
    add(3,  0, 1, 0, 0, MCd,  0, 0, 0);
    add(8,  0, 0, 0, 0, MCd,  0, 0, 0);
    add(6,  0, 1, 0, 0, MCd,  0, 0, 0);
    add(1,  0, 1, 0, 0, MClk, 0, 0, 1);
    add(3,  0, 1, 0, 0, MClk, 0, 0, 0);
    add(8,  0, 0, 0, 0, MClk, 0, 0, 0);
    // Pause: 3-cycle glitch ignored, then two clean presses
    add(3,  0, 0, 1, 0, MClk, 0, 0, 0);
    add(8,  0, 0, 0, 0, MClk, 0, 0, 0);
    add(6,  0, 0, 1, 0, MClk, 0, 0, 0);
    add(4,  0, 0, 1, 0, MClk, 1, 0, 0);
    add(8,  0, 0, 0, 0, MClk, 1, 0, 0);
    add(6,  0, 0, 1, 0, MClk, 1, 0, 0);
    add(4,  0, 0, 1, 0, MClk, 0, 0, 0);
    add(8,  0, 0, 0, 0, MClk, 0, 0, 0);
    // Stopwatch with pause=1, then mode+clear together
    add(6,  0, 1, 0, 0, MClk, 0, 0, 0);
    add(1,  0, 1, 0, 0, MSw,  0, 0, 1);
    add(3,  0, 1, 0, 0, MSw,  0, 0, 0);
    add(8,  0, 0, 0, 0, MSw,  0, 0, 0);
    add(6,  0, 0, 1, 0, MSw,  0, 0, 0);
    add(4,  0, 0, 1, 0, MSw,  1, 0, 0);
    add(8,  0, 0, 0, 0, MSw,  1, 0, 0);
    add(6,  0, 1, 0, 1, MSw,  1, 0, 0);
    add(1,  0, 1, 0, 1, MCd,  0, 1, 1);
    add(3,  0, 1, 0, 1, MCd,  0, 0, 0);
    add(8,  0, 0, 0, 0, MCd,  0, 0, 0);
    // Clear held 50 cycles gives one pulse; a second press gives another
    add(6,  0, 0, 0, 1, MCd,  0, 0, 0);
    add(1,  0, 0, 0, 1, MCd,  0, 1, 0);
    add(43, 0, 0, 0, 1, MCd,  0, 0, 0);
    add(8,  0, 0, 0, 0, MCd,  0, 0, 0);
    add(6,  0, 0, 0, 1, MCd,  0, 0, 0);
    add(1,  0, 0, 0, 1, MCd,  0, 1, 0);
    add(3,  0, 0, 0, 1, MCd,  0, 0, 0);
    add(8,  0, 0, 0, 0, MCd,  0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset         = vecs[i].rst;
      bus.btn_mode  = vecs[i].m;
      bus.btn_pause = vecs[i].p;
      bus.btn_clear = vecs[i].c;
      step();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      check($sformatf("onehot%0d", i),
            32'($countones({bus.mode_clock, bus.mode_stopwatch, bus.mode_countdown})), 32'd1);
    end

    // Reset lands while btn_mode is part-way through debounce
    bus.btn_mode = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("rst_mid_debounce", 32'(outs()), 32'({MClk, 3'b000}));
    reset = 1'b0;
    edges = 0;
    while (edges < 20 && !bus.mode_stopwatch) begin
      step();
      edges++;
    end
    check("post_reset_latency", 32'(edges), 32'(Deb + 3));
    check("post_reset_mode", 32'(outs()), 32'({MSw, 3'b001}));
    bus.btn_mode = 1'b0;
    step();
    check("post_reset_pulse_end", 32'(outs()), 32'({MSw, 3'b000}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_input_ctrl.md
Name: mode_input_ctrl

Overview:
- Front-end controller for the clock/stopwatch/countdown top level.
- Conditions three raw pushbuttons: 2-flop synchroniser, debounce, rising-edge detect.
- Drives the registered one-hot mode selects (clock / stopwatch / countdown), the pause level and the one-cycle clear pulse that the top level and its timekeeping sub-blocks consume.
- Replaces direct wiring of board switches into the mode-select mux.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronised input must differ from its debounced state before that state flips (10 ms at 50 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 20, width of each debounce counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_mode  input  1  raw async pushbutton, active-high; a press advances the mode.
- btn_pause  input  1  raw async pushbutton, active-high; a press toggles pause.
- btn_clear  input  1  raw async pushbutton, active-high; a press requests a clear.
- mode_clock  output  1  one-hot mode select: clock display.
- mode_stopwatch  output  1  one-hot mode select: stopwatch.
- mode_countdown  output  1  one-hot mode select: countdown.
- pause  output  1  level; 1 = timekeeping halted.
- clear  output  1  one-cycle pulse; resets the active counters downstream.
- mode_changed  output  1  one-cycle pulse in the same cycle the mode outputs take a new value.

Behaviour:
- Reset (reset=1 at a clk edge) sets:
  - mode_clock=1, mode_stopwatch=0, mode_countdown=0
  - pause=0, clear=0, mode_changed=0
  - all synchroniser flops, debounced states and counters to 0
- Reset has priority over every other event, including mid-debounce and mid-press.
- Synchroniser: each button passes through two flops (sync = raw delayed 2 cycles).
- Debounce, per button, with stable state S and counter C:
  - If sync == S: C <= 0.
  - Else if C == DEBOUNCE_CYCLES-1: S <= sync, C <= 0.
  - Else: C <= C+1.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles resets C and never changes S.
- Edge detect: press = S rising (S=1 now, 0 previous cycle). Release edges produce nothing.
- Latency:
  - Raw input first sampled high at edge t, held steady: S=1 after edge t+DEBOUNCE_CYCLES+1.
  - Press-driven output changes are visible after edge t+DEBOUNCE_CYCLES+2, i.e. DEBOUNCE_CYCLES+3 edges after the first sample.
  - Exact, no jitter allowed.
- Mode FSM, states CLOCK, STOPWATCH, COUNTDOWN, one-hot registered outputs, exactly one output high at all times:
  - Mode press: CLOCK->STOPWATCH->COUNTDOWN->CLOCK (wrap).
  - mode_changed=1 for exactly the cycle in which the new mode is first visible.
- Pause:
  - Toggles on a pause press.
  - Forced to 0 on any mode change.
- Clear:
  - A clear press gives clear=1 for exactly one cycle.
  - Pause and mode are unaffected.
  - A held button gives only one pulse.
- Simultaneous presses in the same cycle:
  - mode + pause: mode advances, pause=0 (mode wins).
  - mode + clear: mode advances, pause=0, clear pulse still issued that same cycle.
  - pause + clear: pause toggles and clear pulses in the same cycle.
  - All three: mode advances, pause=0, clear=1.
- Held button: no auto-repeat; the next press requires a debounced release (S back to 0) followed by a new debounced press.
- Pulse spacing: the minimum spacing between two presses of the same button is 2*DEBOUNCE_CYCLES cycles, as a consequence of the debounce rule.

Test Plan:
Run all scenarios with DEBOUNCE_CYCLES=4.
1. Reset then idle 20 cycles -> mode_clock=1, others 0, pause=0, clear=0, mode_changed=0 throughout.
2. btn_mode held high from edge t for 12 cycles -> mode_stopwatch=1 and mode_changed=1 first visible after edge t+6; mode_changed back to 0 the next cycle. Three full press/release cycles return to mode_clock=1, wrapping once.
3. btn_pause glitch high for 3 cycles, then low -> pause stays 0. A clean 10-cycle press -> pause=1. A second clean press -> pause=0.
4. pause=1 in STOPWATCH; btn_mode and btn_clear rise on the same edge -> after 6 edges: mode_countdown=1, pause=0, clear=1 and mode_changed=1 for one cycle each.
5. btn_clear held high 50 cycles -> exactly one clear pulse. Release, then press again -> a second single pulse.
6. reset asserted while btn_mode is 2 cycles into debounce, then released with btn_mode still high -> mode_clock=1 right after reset; the mode advances only after a full DEBOUNCE_CYCLES+3 edges counted from the first post-reset sample.
